receiver_arbiter: RTL and testbench

- Buffered, fair front end for a node's incoming instruction traffic.
- Accepts 32-bit instructions from the right neighbour, left neighbour and self. Each source has its own FIFO.
- Arbitrates round-robin among non-empty FIFOs and presents one instruction at a time to the node's processing unit over a valid/ack handshake.
- Counts instructions dropped on FIFO overflow.

---
 rtl/receiver_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_receiver_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/receiver_arbiter.sv
// receiver_arbiter
//   Buffered, fair front end for a node's incoming instruction traffic. Three per-source FIFOs
//   (right, left, self) feed a round-robin arbiter that loads one instruction at a time into an
//   output register. The output register is handed to the processing unit over a valid/ack
//   handshake. Pushes to a full FIFO are dropped and counted in a saturating counter.
//
// Ports
//   clk           system clock, rising-edge
//   reset         synchronous, active-high reset; dominates everything on the same edge
//   check_r/l/s   push strobes for the right/left/self instruction inputs
//   in_sig_*      instruction data per source
//   sig_ack       processing unit consumes selected_sig this cycle
//   selected_sig  instruction presented to the processing unit
//   sig_alert     selected_sig and s are valid
//   s             source of selected_sig: 00 right, 01 left, 10 self, 11 none
//   fifo_full     per-source full flags: [0] right, [1] left, [2] self
//   drop_count    saturating count of dropped pushes
module receiver_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             check_r,
    input  logic             check_l,
    input  logic             check_s,
    input  logic [WIDTH-1:0] in_sig_right,
    input  logic [WIDTH-1:0] in_sig_left,
    input  logic [WIDTH-1:0] in_sig_self,
    input  logic             sig_ack,
    output logic [WIDTH-1:0] selected_sig,
    output logic             sig_alert,
    output logic [1:0]       s,
    output logic [2:0]       fifo_full,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned NSRC = 3;
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]      FullCnt = (AW + 1)'(DEPTH);
    localparam logic [CNT_W+1:0] MaxDrop = {2'b00, {CNT_W{1'b1}}};

    typedef enum logic {StEmpty, StValid} state_e;

    // FIFO storage and bookkeeping. Count is one bit wider than the pointers so full and empty
    // stay distinguishable when the pointers coincide.
    logic [WIDTH-1:0] r_mem  [NSRC][DEPTH];
    logic [AW-1:0]    r_wptr [NSRC];
    logic [AW-1:0]    r_rptr [NSRC];
    logic [AW:0]      r_cnt  [NSRC];
    logic [NSRC-1:0]  r_full;

    // Output register and arbiter state
    state_e           r_state;
    logic [WIDTH-1:0] r_sel;
    logic [1:0]       r_s;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_drop;

    logic [NSRC-1:0]  w_check;
    logic [WIDTH-1:0] w_in       [NSRC];
    logic [NSRC-1:0]  w_nonempty;
    logic [NSRC-1:0]  w_push_ok;
    logic [NSRC-1:0]  w_drop;
    logic [NSRC-1:0]  w_pop;
    logic [AW:0]      w_cnt_next [NSRC];
    logic             w_load;
    logic             w_grant_vld;
    logic [1:0]       w_grant;
    logic [1:0]       w_cand;
    logic [WIDTH-1:0] w_head;
    logic [CNT_W+1:0] w_drop_sum;
    logic [CNT_W-1:0] w_drop_next;

    function automatic logic [1:0] rr_next(input logic [1:0] cur);
        return (cur == 2'd2) ? 2'd0 : cur + 2'd1;
    endfunction

    assign w_check = {check_s, check_l, check_r};
    assign w_in[0] = in_sig_right;
    assign w_in[1] = in_sig_left;
    assign w_in[2] = in_sig_self;

    // Full test uses the pre-edge count, so a pop on the same edge cannot rescue a push.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            w_nonempty[i] = (r_cnt[i] != '0);
            w_push_ok[i]  = w_check[i] && (r_cnt[i] != FullCnt);
            w_drop[i]     = w_check[i] && (r_cnt[i] == FullCnt);
        end
    end

    // Round-robin search starting at the source after the last grant.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = 2'd0;
        w_cand      = rr_next(r_last);
        for (int k = 0; k < NSRC; k++) begin
            if (!w_grant_vld && w_nonempty[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_cand;
            end
            w_cand = rr_next(w_cand);
        end
    end

    assign w_load = ((r_state == StEmpty) || sig_ack) && w_grant_vld;
    assign w_head = r_mem[w_grant][r_rptr[w_grant]];

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            w_pop[i]      = w_load && (w_grant == 2'(i));
            w_cnt_next[i] = r_cnt[i];
            if (w_push_ok[i] && !w_pop[i]) begin
                w_cnt_next[i] = r_cnt[i] + 1'b1;
            end else if (!w_push_ok[i] && w_pop[i]) begin
                w_cnt_next[i] = r_cnt[i] - 1'b1;
            end
        end
    end

    // Up to three drops per edge, saturating.
    always_comb begin
        w_drop_sum = {2'b00, r_drop} + (CNT_W + 2)'(w_drop[0]) + (CNT_W + 2)'(w_drop[1])
                   + (CNT_W + 2)'(w_drop[2]);
        w_drop_next = (w_drop_sum > MaxDrop) ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
    end

    // Storage carries no reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (w_push_ok[i]) begin
                r_mem[i][r_wptr[i]] <= w_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSRC; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_full <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (w_push_ok[i]) begin
                    r_wptr[i] <= r_wptr[i] + 1'b1;
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + 1'b1;
                end
                r_cnt[i]  <= w_cnt_next[i];
                r_full[i] <= (w_cnt_next[i] == FullCnt);
            end
        end
    end

    // Output register FSM. r_last resets to self so right has first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StEmpty;
            r_sel   <= '0;
            r_s     <= 2'b11;
            r_last  <= 2'd2;
            r_drop  <= '0;
        end else begin
            r_drop <= w_drop_next;
            unique case (r_state)
                StEmpty: begin
                    if (w_load) begin
                        r_sel   <= w_head;
                        r_s     <= w_grant;
                        r_last  <= w_grant;
                        r_state <= StValid;
                    end
                end
                StValid: begin
                    if (w_load) begin
                        r_sel  <= w_head;
                        r_s    <= w_grant;
                        r_last <= w_grant;
                    end else if (sig_ack) begin
                        // Retire with nothing queued; data holds its last value.
                        r_s     <= 2'b11;
                        r_state <= StEmpty;
                    end
                end
                default: r_state <= StEmpty;
            endcase
        end
    end

    assign selected_sig = r_sel;
    assign sig_alert    = (r_state == StValid);
    assign s            = r_s;
    assign fifo_full    = r_full;
    assign drop_count   = r_drop;

endmodule

// File: tb/tb_receiver_arbiter.sv
// tb_receiver_arbiter
//   Self-checking bench for receiver_arbiter. A queue-based reference model predicts the
//   output register, grant source, full flags and drop counter after every edge. Directed
//   scenarios are followed by a long randomized run.
module tb_receiver_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 8;
    localparam int          MAXD  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             check_r, check_l, check_s;
    logic [WIDTH-1:0] in_sig_right, in_sig_left, in_sig_self;
    logic             sig_ack;
    logic [WIDTH-1:0] selected_sig;
    logic             sig_alert;
    logic [1:0]       s;
    logic [2:0]       fifo_full;
    logic [CNT_W-1:0] drop_count;

    always #5 clk = ~clk;

    receiver_arbiter #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .check_r     (check_r),
        .check_l     (check_l),
        .check_s     (check_s),
        .in_sig_right(in_sig_right),
        .in_sig_left (in_sig_left),
        .in_sig_self (in_sig_self),
        .sig_ack     (sig_ack),
        .selected_sig(selected_sig),
        .sig_alert   (sig_alert),
        .s           (s),
        .fifo_full   (fifo_full),
        .drop_count  (drop_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one queue per source plus the presented instruction.
    logic [WIDTH-1:0] mq [3][$];
    bit               m_valid;
    logic [WIDTH-1:0] m_sig;
    int               m_s;
    int               m_last;
    int               m_drop;

    task automatic model_edge(input bit rst, input bit [2:0] chk,
                              input logic [WIDTH-1:0] dr, input logic [WIDTH-1:0] dl,
                              input logic [WIDTH-1:0] ds, input bit ack);
        int               sz [3];
        logic [WIDTH-1:0] d  [3];
        bit               got;
        d[0] = dr;
        d[1] = dl;
        d[2] = ds;
        if (rst) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_valid = 0;
            m_sig   = '0;
            m_s     = 3;
            m_last  = 2;
            m_drop  = 0;
        end else begin
            for (int i = 0; i < 3; i++) sz[i] = mq[i].size();
            got = 0;
            if (!m_valid || ack) begin
                for (int k = 1; k <= 3; k++) begin
                    int c;
                    c = (m_last + k) % 3;
                    if (!got && sz[c] > 0) begin
                        got    = 1;
                        m_sig  = mq[c].pop_front();
                        m_s    = c;
                        m_last = c;
                    end
                end
            end
            if (got) begin
                m_valid = 1;
            end else if (m_valid && ack) begin
                m_valid = 0;
                m_s     = 3;
            end
            for (int i = 0; i < 3; i++) begin
                if (chk[i]) begin
                    if (sz[i] < DEPTH) mq[i].push_back(d[i]);
                    else if (m_drop < MAXD) m_drop++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [2:0] ff;
        for (int i = 0; i < 3; i++) ff[i] = (mq[i].size() == DEPTH);
        check_val("sig_alert", sig_alert, m_valid);
        check_val("selected_sig", selected_sig, m_sig);
        check_val("s", s, m_s);
        check_val("fifo_full", fifo_full, ff);
        check_val("drop_count", drop_count, m_drop);
    endtask

    // One clock: drive on the falling edge, model the rising edge, sample 1 ns later.
    task automatic step(input bit rst, input bit [2:0] chk, input logic [WIDTH-1:0] dr,
                        input logic [WIDTH-1:0] dl, input logic [WIDTH-1:0] ds, input bit ack);
        @(negedge clk);
        reset        = rst;
        check_r      = chk[0];
        check_l      = chk[1];
        check_s      = chk[2];
        in_sig_right = dr;
        in_sig_left  = dl;
        in_sig_self  = ds;
        sig_ack      = ack;
        @(posedge clk);
        model_edge(rst, chk, dr, dl, ds, ack);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input bit ack);
        for (int i = 0; i < n; i++) step(0, 3'b000, '0, '0, '0, ack);
    endtask

    initial begin
        reset = 1'b1;
        check_r = 0; check_l = 0; check_s = 0;
        in_sig_right = '0; in_sig_left = '0; in_sig_self = '0;
        sig_ack = 0;

        // Reset state
        step(1, 3'b000, '0, '0, '0, 0);
        check_val("rst_s", s, 2'b11);
        check_val("rst_alert", sig_alert, 1'b0);

        // Single push with ack held
        step(0, 3'b001, 42, 0, 0, 1);
        check_val("single_lat", sig_alert, 1'b0);
        step(0, 3'b000, 0, 0, 0, 1);
        check_val("single_sel", selected_sig, 42);
        check_val("single_s", s, 2'b00);
        idle(1, 1);
        check_val("single_done_s", s, 2'b11);

        // Simultaneous pushes from all three sources
        step(0, 3'b111, 500, 800, 4, 1);
        idle(4, 1);

        // Back-pressure
        step(0, 3'b001, 1, 0, 0, 0);
        step(0, 3'b001, 2, 0, 0, 0);
        idle(10, 0);
        check_val("bp_hold", selected_sig, 1);
        idle(3, 1);

        // Overflow of the right FIFO
        for (int v = 10; v <= 15; v++) step(0, 3'b001, v, 0, 0, 0);
        check_val("ovf_drop", drop_count, 1);
        check_val("ovf_full", fifo_full, 3'b001);
        check_val("ovf_sel", selected_sig, 10);
        idle(6, 1);
        check_val("ovf_clear", fifo_full, 3'b000);

        // Fairness between right and left
        for (int i = 0; i < 8; i++) step(0, 3'b011, 100 + i, 200 + i, 0, 1);
        idle(10, 1);

        // Reset mid-operation with a concurrent left push
        step(0, 3'b111, 31, 32, 33, 0);
        step(0, 3'b111, 34, 35, 36, 0);
        step(1, 3'b010, 0, 99, 0, 0);
        check_val("mid_rst_full", fifo_full, 3'b000);
        step(0, 3'b001, 7, 0, 0, 1);
        step(0, 3'b000, 0, 0, 0, 1);
        check_val("mid_rst_sel", selected_sig, 7);
        idle(2, 1);

        // Drop counter saturation
        for (int i = 0; i < 100; i++) step(0, 3'b111, $urandom, $urandom, $urandom, 0);
        check_val("drop_sat", drop_count, MAXD);
        step(1, 3'b000, 0, 0, 0, 0);

        // Randomized traffic with varying ack pressure and occasional resets
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                bit [2:0] chk;
                bit       ack;
                bit       rst;
                chk = 3'($urandom);
                ack = ($urandom_range(0, 3) < ph + 1);
                rst = ($urandom_range(0, 299) == 0);
                step(rst, chk, $urandom, $urandom, $urandom, ack);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
